data_bus_matrix_n: RTL and testbench

Parametrised data-side bus matrix connecting the core's load/store port to `NUM_SLAVES` memory-mapped slaves (Ram, Vga, Timer0, future peripherals) with a single-clock handshake FSM. It generalises the fixed three-slave data bus matrix in three ways:
- slave count, data width and address decode are parameters;
- a read and a write strobed in the same cycle are both served, in sequence;
- an unmapped address, and optionally a stalled slave, terminates with an error response instead of hanging the core.

---
 rtl/data_bus_matrix_n.sv | 233 +++++++++++++++++++++++
 tb/tb_data_bus_matrix_n.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_matrix_n.sv
// Data-side bus matrix: one load/store port fanned out to NUM_SLAVES address-decoded slaves.
// Optional per-access wait limit enabled by defining DBM_TIMEOUT_EN.
module data_bus_matrix_n #(
    parameter int NUM_SLAVES     = 3,
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int SEL_LSB        = 28,
    parameter int SEL_W          = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic                           ReadReqIn,
    input  logic [ADDR_W-1:0]              ReadAddrIn,
    input  logic                           WriteReqIn,
    input  logic [ADDR_W-1:0]              WriteAddrIn,
    input  logic [DATA_W-1:0]              WriteDataIn,
    input  logic [DATA_W/8-1:0]            WriteStrbIn,
    output logic                           BusBusy,
    output logic [DATA_W-1:0]              ReadDataOut,
    output logic                           ReadDataReady,
    output logic                           WriteDataOver,
    output logic                           BusError,
    output logic [NUM_SLAVES*ADDR_W-1:0]   ReadAddrOut,
    output logic [NUM_SLAVES-1:0]          ReadEnableOut,
    input  logic [NUM_SLAVES*DATA_W-1:0]   ReadDataIn,
    input  logic [NUM_SLAVES-1:0]          ReadReadyIn,
    output logic [NUM_SLAVES*ADDR_W-1:0]   WriteAddrOut,
    output logic [NUM_SLAVES*DATA_W-1:0]   WriteDataOut,
    output logic [NUM_SLAVES*DATA_W/8-1:0] WriteStrbOut,
    output logic [NUM_SLAVES-1:0]          WriteEnableOut,
    input  logic [NUM_SLAVES-1:0]          WriteReadyIn
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [SEL_W:0] SEL_LIM = (SEL_W + 1)'(NUM_SLAVES);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || (2 ** SEL_W) < NUM_SLAVES || TIMEOUT_CYCLES < 2)
    begin : g_bad_params
        $error("data_bus_matrix_n: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_RESP, S_ERR} state_t;

    state_t                         state_q, state_d;
    logic                           op_wr_q, op_wr_d;
    logic                           wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0]              rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]              wr_data_q, wr_data_d, rd_data_q, rd_data_d;
    logic [STRB_W-1:0]              wr_strb_q, wr_strb_d;
    logic                           busy_q, busy_d, rd_rdy_q, rd_rdy_d;
    logic                           wr_over_q, wr_over_d, err_q, err_d;
    logic [NUM_SLAVES-1:0]          rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [NUM_SLAVES*ADDR_W-1:0]   rd_lane_a_q, rd_lane_a_d, wr_lane_a_q, wr_lane_a_d;
    logic [NUM_SLAVES*DATA_W-1:0]   wr_lane_d_q, wr_lane_d_d;
    logic [NUM_SLAVES*STRB_W-1:0]   wr_lane_s_q, wr_lane_s_d;

    logic [SEL_W-1:0]  in_rd_sel, in_wr_sel, rd_sel_q, wr_sel_q, nxt_rd_sel, nxt_wr_sel;
    logic              in_rd_ok, in_wr_ok, wr_q_ok;
    logic [DATA_W-1:0] rd_mux;
    logic              rd_hit, wr_hit, tmo_hit;

    assign in_rd_sel  = ReadAddrIn[SEL_LSB +: SEL_W];
    assign in_wr_sel  = WriteAddrIn[SEL_LSB +: SEL_W];
    assign rd_sel_q   = rd_addr_q[SEL_LSB +: SEL_W];
    assign wr_sel_q   = wr_addr_q[SEL_LSB +: SEL_W];
    assign nxt_rd_sel = rd_addr_d[SEL_LSB +: SEL_W];
    assign nxt_wr_sel = wr_addr_d[SEL_LSB +: SEL_W];
    assign in_rd_ok   = {1'b0, in_rd_sel} < SEL_LIM;
    assign in_wr_ok   = {1'b0, in_wr_sel} < SEL_LIM;
    assign wr_q_ok    = {1'b0, wr_sel_q} < SEL_LIM;

    // Ready only counts when it comes from the slave whose enable we are driving.
    always_comb begin
        rd_mux = '0;
        rd_hit = 1'b0;
        wr_hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (rd_sel_q == SEL_W'(i)) begin
                rd_mux = ReadDataIn[i*DATA_W +: DATA_W];
                rd_hit = ReadReadyIn[i] & rd_en_q[i];
            end
            if (wr_sel_q == SEL_W'(i))
                wr_hit = WriteReadyIn[i] & wr_en_q[i];
        end
    end

`ifdef DBM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_q, tmo_d;

    assign tmo_hit = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign tmo_d   = ((state_q == S_RD || state_q == S_WR) && state_d == state_q) ?
                     tmo_q + 1'b1 : '0;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) tmo_q <= '0;
        else          tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_wr_d   = op_wr_q;
        wr_pend_d = wr_pend_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_strb_d = wr_strb_q;
        rd_data_d = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (wr_pend_q) begin
                    wr_pend_d = 1'b0;
                    op_wr_d   = 1'b1;
                    state_d   = wr_q_ok ? S_WR : S_ERR;
                end else if (ReadReqIn) begin
                    op_wr_d   = 1'b0;
                    rd_addr_d = ReadAddrIn;
                    state_d   = in_rd_ok ? S_RD : S_ERR;
                    if (WriteReqIn) begin
                        wr_pend_d = 1'b1;
                        wr_addr_d = WriteAddrIn;
                        wr_data_d = WriteDataIn;
                        wr_strb_d = WriteStrbIn;
                    end
                end else if (WriteReqIn) begin
                    op_wr_d   = 1'b1;
                    wr_addr_d = WriteAddrIn;
                    wr_data_d = WriteDataIn;
                    wr_strb_d = WriteStrbIn;
                    state_d   = in_wr_ok ? S_WR : S_ERR;
                end
            end
            S_RD: begin
                if (rd_hit) begin
                    rd_data_d = rd_mux;
                    state_d   = S_RESP;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_WR: begin
                if (wr_hit)       state_d = S_RESP;
                else if (tmo_hit) state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ERR && !op_wr_d)
            rd_data_d = '0;
    end

    // Every output is the registered image of the state being entered.
    always_comb begin
        rd_rdy_d    = (state_d == S_RESP || state_d == S_ERR) && !op_wr_d;
        wr_over_d   = (state_d == S_RESP || state_d == S_ERR) && op_wr_d;
        err_d       = (state_d == S_ERR);
        busy_d      = (state_d != S_IDLE) || wr_pend_d;
        rd_en_d     = '0;
        wr_en_d     = '0;
        rd_lane_a_d = '0;
        wr_lane_a_d = '0;
        wr_lane_d_d = '0;
        wr_lane_s_d = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            rd_en_d[i] = (state_d == S_RD) && (nxt_rd_sel == SEL_W'(i));
            wr_en_d[i] = (state_d == S_WR) && (nxt_wr_sel == SEL_W'(i));
            if (rd_en_d[i])
                rd_lane_a_d[i*ADDR_W +: ADDR_W] = rd_addr_d;
            if (wr_en_d[i]) begin
                wr_lane_a_d[i*ADDR_W +: ADDR_W] = wr_addr_d;
                wr_lane_d_d[i*DATA_W +: DATA_W] = wr_data_d;
                wr_lane_s_d[i*STRB_W +: STRB_W] = wr_strb_d;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q     <= S_IDLE;
            op_wr_q     <= 1'b0;
            wr_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_strb_q   <= '0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
            rd_rdy_q    <= 1'b0;
            wr_over_q   <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= '0;
            wr_en_q     <= '0;
            rd_lane_a_q <= '0;
            wr_lane_a_q <= '0;
            wr_lane_d_q <= '0;
            wr_lane_s_q <= '0;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            wr_pend_q   <= wr_pend_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_strb_q   <= wr_strb_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
            rd_rdy_q    <= rd_rdy_d;
            wr_over_q   <= wr_over_d;
            err_q       <= err_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            rd_lane_a_q <= rd_lane_a_d;
            wr_lane_a_q <= wr_lane_a_d;
            wr_lane_d_q <= wr_lane_d_d;
            wr_lane_s_q <= wr_lane_s_d;
        end
    end

    assign BusBusy        = busy_q;
    assign ReadDataOut    = rd_data_q;
    assign ReadDataReady  = rd_rdy_q;
    assign WriteDataOver  = wr_over_q;
    assign BusError       = err_q;
    assign ReadEnableOut  = rd_en_q;
    assign WriteEnableOut = wr_en_q;
    assign ReadAddrOut    = rd_lane_a_q;
    assign WriteAddrOut   = wr_lane_a_q;
    assign WriteDataOut   = wr_lane_d_q;
    assign WriteStrbOut   = wr_lane_s_q;

endmodule

// File: tb/tb_data_bus_matrix_n.sv
// Scoreboard bench for data_bus_matrix_n with behavioural slaves (per-slave wait count, silence, stray ready).
// Define DBM_TIMEOUT_EN to exercise the wait-limit path with TIMEOUT_CYCLES=4.
module tb_data_bus_matrix_n;
    localparam int NS = 3;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;
`ifdef DBM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 256;
`endif

    logic               ACLK = 1'b0;
    logic               ARESETn;
    logic               ReadReqIn, WriteReqIn;
    logic [AW-1:0]      ReadAddrIn, WriteAddrIn;
    logic [DW-1:0]      WriteDataIn;
    logic [SW-1:0]      WriteStrbIn;
    logic               BusBusy, ReadDataReady, WriteDataOver, BusError;
    logic [DW-1:0]      ReadDataOut;
    logic [NS*AW-1:0]   ReadAddrOut, WriteAddrOut;
    logic [NS-1:0]      ReadEnableOut, WriteEnableOut, ReadReadyIn, WriteReadyIn;
    logic [NS*DW-1:0]   ReadDataIn, WriteDataOut;
    logic [NS*SW-1:0]   WriteStrbOut;

    data_bus_matrix_n #(
        .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_LSB(28), .SEL_W(3), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ReadReqIn(ReadReqIn), .ReadAddrIn(ReadAddrIn),
        .WriteReqIn(WriteReqIn), .WriteAddrIn(WriteAddrIn),
        .WriteDataIn(WriteDataIn), .WriteStrbIn(WriteStrbIn),
        .BusBusy(BusBusy), .ReadDataOut(ReadDataOut), .ReadDataReady(ReadDataReady),
        .WriteDataOver(WriteDataOver), .BusError(BusError),
        .ReadAddrOut(ReadAddrOut), .ReadEnableOut(ReadEnableOut),
        .ReadDataIn(ReadDataIn), .ReadReadyIn(ReadReadyIn),
        .WriteAddrOut(WriteAddrOut), .WriteDataOut(WriteDataOut),
        .WriteStrbOut(WriteStrbOut), .WriteEnableOut(WriteEnableOut),
        .WriteReadyIn(WriteReadyIn)
    );

    always #5 ACLK = ~ACLK;

    int unsigned cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Slave models: ready after wait_n[i] cycles of enable, unless silent.
    int unsigned   wait_n [NS];
    int unsigned   rcnt   [NS];
    int unsigned   wcnt   [NS];
    logic [DW-1:0] rdat   [NS];
    logic [NS-1:0] silent, stray;

    always_comb begin
        ReadDataIn   = '0;
        ReadReadyIn  = '0;
        WriteReadyIn = '0;
        for (int i = 0; i < NS; i++) begin
            ReadDataIn[i*DW +: DW] = rdat[i];
            ReadReadyIn[i]  = stray[i] | (ReadEnableOut[i] & ~silent[i] & (rcnt[i] == wait_n[i]));
            WriteReadyIn[i] = stray[i] | (WriteEnableOut[i] & ~silent[i] & (wcnt[i] == wait_n[i]));
        end
    end

    always @(posedge ACLK) begin
        for (int i = 0; i < NS; i++) begin
            rcnt[i] <= ReadEnableOut[i] ? rcnt[i] + 1 : 0;
            wcnt[i] <= WriteEnableOut[i] ? wcnt[i] + 1 : 0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        bit            wr;
        bit            err;
        bit            tchk;
        int unsigned   cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];

    task automatic expect_done(input bit wr, input bit err, input bit tchk,
                               input int unsigned c, input logic [DW-1:0] d);
        exp_t e;
        e.wr = wr; e.err = err; e.tchk = tchk; e.cyc = c; e.data = d;
        sbq.push_back(e);
    endtask

    always @(negedge ACLK) begin
        exp_t e;
        if (ReadDataReady || WriteDataOver) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", 1'b1, 1'b0);
            end else begin
                e = sbq.pop_front();
                chk("done_kind", {ReadDataReady, WriteDataOver}, {!e.wr, e.wr});
                if (e.tchk) chk("done_cycle", cyc, e.cyc);
                chk("done_err", BusError, e.err);
                if (!e.wr) chk("rd_data", ReadDataOut, e.data);
            end
        end else if (BusError) begin
            chk("err_without_done", BusError, 1'b0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge ACLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned   t0;
        int            n;
        bit            seen;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        ARESETn = 1'b0; ReadReqIn = 1'b0; WriteReqIn = 1'b0;
        ReadAddrIn = '0; WriteAddrIn = '0; WriteDataIn = '0; WriteStrbIn = '0;
        silent = '0; stray = '0;
        for (int i = 0; i < NS; i++) begin
            wait_n[i] = 0;
            rdat[i]   = '0;
        end

        // Reset state
        tick(3);
        chk("rst_busy", BusBusy, 0);
        chk("rst_rdy", ReadDataReady, 0);
        chk("rst_wover", WriteDataOver, 0);
        chk("rst_err", BusError, 0);
        chk("rst_ren", ReadEnableOut, 0);
        chk("rst_wen", WriteEnableOut, 0);
        chk("rst_rdata", ReadDataOut, 0);
        chk("rst_lanes", |{ReadAddrOut, WriteAddrOut, WriteDataOut, WriteStrbOut}, 0);
        ARESETn = 1'b1;
        tick(2);

        // Zero-wait read of slave 1
        rdat[1] = 64'hDEAD_BEEF;
        a = 64'h0000_0000_1000_0040;
        t0 = cyc; ReadReqIn = 1'b1; ReadAddrIn = a;
        expect_done(0, 0, 1, t0 + 2, 64'hDEAD_BEEF);
        tick(); ReadReqIn = 1'b0;
        chk("t1_ren", ReadEnableOut, 3'b010);
        chk("t1_raddr", ReadAddrOut[AW +: AW], a);
        chk("t1_raddr_other", ReadAddrOut[0 +: AW] | ReadAddrOut[2*AW +: AW], 0);
        chk("t1_busy", BusBusy, 1);
        tick();
        chk("t1_ren_off", ReadEnableOut, 0);
        tick(2);

        // Write to slave 0 with three wait cycles
        wait_n[0] = 3;
        a = 64'h0000_0000_0000_0100; d = 64'h1122_3344_5566_7788;
        t0 = cyc; WriteReqIn = 1'b1; WriteAddrIn = a; WriteDataIn = d; WriteStrbIn = 8'h0F;
        expect_done(1, 0, 1, t0 + 5, '0);
        tick(); WriteReqIn = 1'b0;
        chk("t2_strb", WriteStrbOut, 24'h00_000F);
        chk("t2_wdata", WriteDataOut[0 +: DW], d);
        chk("t2_waddr", WriteAddrOut[0 +: AW], a);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t2_wen%0d", k), WriteEnableOut, 3'b001);
            tick();
        end
        chk("t2_wen_off", WriteEnableOut, 0);
        wait_n[0] = 0;
        tick(2);

        // Same-cycle read (slave 2) and write (slave 0)
        rdat[2] = 64'hCAFE_F00D_0123_4567;
        t0 = cyc;
        ReadReqIn = 1'b1;  ReadAddrIn = 64'h0000_0000_2000_0008;
        WriteReqIn = 1'b1; WriteAddrIn = 64'h0000_0000_0000_0200;
        WriteDataIn = 64'hA5A5_5A5A_A5A5_5A5A; WriteStrbIn = 8'hFF;
        expect_done(0, 0, 1, t0 + 2, 64'hCAFE_F00D_0123_4567);
        expect_done(1, 0, 1, t0 + 5, '0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            ReadReqIn = 1'b0; WriteReqIn = 1'b0;
            chk($sformatf("t3_busy%0d", k), BusBusy, (k <= 5));
            chk($sformatf("t3_ren%0d", k), ReadEnableOut, (k == 1) ? 3'b100 : 3'b000);
            chk($sformatf("t3_wen%0d", k), WriteEnableOut, (k == 4) ? 3'b001 : 3'b000);
        end
        tick(2);
        chk("rdata_hold", ReadDataOut, 64'hCAFE_F00D_0123_4567);

        // Unmapped read: index 7
        t0 = cyc; ReadReqIn = 1'b1; ReadAddrIn = 64'h0000_0000_7000_0000;
        expect_done(0, 1, 1, t0 + 1, '0);
        tick(); ReadReqIn = 1'b0;
        chk("t4_ren", ReadEnableOut, 0);
        chk("t4_busy", BusBusy, 1);
        tick();
        chk("t4_busy_off", BusBusy, 0);

        // Unmapped write: index 5, never reaches a slave
        t0 = cyc; WriteReqIn = 1'b1; WriteAddrIn = 64'h0000_0000_5000_0000;
        WriteDataIn = 64'hFFFF_FFFF_FFFF_FFFF;
        expect_done(1, 1, 1, t0 + 1, '0);
        tick(); WriteReqIn = 1'b0;
        chk("t5_wen", WriteEnableOut, 0);
        chk("t5_wlanes", |{WriteDataOut, WriteAddrOut, WriteStrbOut}, 0);
        tick(2);

        // Ready without enable is ignored
        stray = 3'b111;
        tick(3);
        chk("t6_busy", BusBusy, 0);
        stray = '0;
        tick();

        // Strobe while busy is ignored
        wait_n[0] = 3; rdat[0] = 64'h0BAD_C0DE_1357_9BDF;
        t0 = cyc; ReadReqIn = 1'b1; ReadAddrIn = 64'h0000_0000_0000_0080;
        expect_done(0, 0, 1, t0 + 5, 64'h0BAD_C0DE_1357_9BDF);
        tick(); ReadReqIn = 1'b0;
        WriteReqIn = 1'b1; WriteAddrIn = 64'h0000_0000_2000_0000;
        tick(); WriteReqIn = 1'b0;
        tick(6);
        chk("t7_idle", BusBusy, 0);
        chk("t7_wen", WriteEnableOut, 0);
        wait_n[0] = 0;

        // Silent slave
        silent[1] = 1'b1;
        ReadReqIn = 1'b1; ReadAddrIn = 64'h0000_0000_1000_0000;
`ifdef DBM_TIMEOUT_EN
        expect_done(0, 1, 0, 0, '0);
        tick(); ReadReqIn = 1'b0;
        n = 0; seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ReadEnableOut[1]) n++;
            if (ReadDataReady) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("tmo_seen", seen, 1);
        chk("tmo_en_cycles", n, 4);
        tick(2);
`else
        tick(); ReadReqIn = 1'b0;
        tick(40);
        chk("hang_busy", BusBusy, 1);
        chk("hang_ren", ReadEnableOut, 3'b010);
        ARESETn = 1'b0;
        tick(2);
        ARESETn = 1'b1;
        chk("hang_rst_busy", BusBusy, 0);
        tick();
`endif

        // Reset in the middle of a write
        WriteReqIn = 1'b1; WriteAddrIn = 64'h0000_0000_1000_0010;
        WriteDataIn = 64'h7777_8888_9999_AAAA; WriteStrbIn = 8'hF0;
        tick(); WriteReqIn = 1'b0;
        chk("t9_wen", WriteEnableOut, 3'b010);
        tick();
        ARESETn = 1'b0;
        tick();
        chk("t9_wen_off", WriteEnableOut, 0);
        chk("t9_ren_off", ReadEnableOut, 0);
        chk("t9_busy", BusBusy, 0);
        chk("t9_wover", WriteDataOver, 0);
        ARESETn = 1'b1; silent[1] = 1'b0;
        tick();

        rdat[2] = 64'h5555_6666_7777_8888;
        t0 = cyc; ReadReqIn = 1'b1; ReadAddrIn = 64'h0000_0000_2000_0100;
        expect_done(0, 0, 1, t0 + 2, 64'h5555_6666_7777_8888);
        tick(); ReadReqIn = 1'b0;
        chk("t10_ren", ReadEnableOut, 3'b100);
        tick(4);

        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
